aio_init_seq: RTL and testbench
===============================

Name: aio_init_seq

Overview:
- Parametrised board-initialisation sequencer for AIO FPGA boards; successor to the fixed four-step init FSM (check RAM, load RAM, compare CRC, read ID).
- Runs N_STAGE sub-tasks strictly in order, one one-cycle enable pulse per stage, and waits for that stage's done/error.
- Adds a per-stage timeout watchdog, bounded retries, and latched failure diagnostics (stage index, cause).
- Sits between the board power-up/control logic and the individual init engines (RAM check, load, CRC, ID read, etc.).

Parameters:
N_STAGE, 4, number of sequential init stages (1..16)
STG_W, 4, width of stage index outputs (must satisfy 2**STG_W >= N_STAGE)
TO_W, 20, width of timeout counter
TIMEOUT, 500000, cycles to wait for done/error per attempt; 0 disables timeout
MAX_RETRY, 2, extra attempts per stage after first failure (0 = no retry)
RTY_W, 2, width of retry counter (must hold MAX_RETRY)

Ports:
sys_clk  in  1  system clock, all logic rising-edge
glbl_rst  in  1  synchronous active-high reset
init_start  in  1  start request; sampled only in IDLE
init_busy  out  1  high from first stage_en until init_ok/init_fail pulse inclusive
init_ok  out  1  one-cycle pulse: all stages completed
init_fail  out  1  one-cycle pulse: a stage failed after all retries
fail_stage  out  STG_W  index of failing stage; latched, valid after init_fail until next accepted init_start
fail_to  out  1  latched with fail_stage: 1 = last attempt timed out, 0 = stage_error
cur_stage  out  STG_W  index of stage currently running
retry_cnt  out  RTY_W  retries used on current stage
stage_en  out  N_STAGE  one-hot one-cycle start pulse to stage k
stage_done  in  N_STAGE  per-stage completion pulse/level
stage_error  in  N_STAGE  per-stage error pulse/level

Behaviour:
- Reset (synchronous, while glbl_rst=1): every output is 0, state = IDLE, counters cleared. Reset mid-sequence aborts immediately; no init_ok/init_fail is emitted.
- States: IDLE, LAUNCH, WAIT, OK, FAIL.
- IDLE: init_start=1 at cycle T goes to LAUNCH, clears fail_stage/fail_to, and sets cur_stage=0, retry_cnt=0.
- LAUNCH (T+1): stage_en[cur_stage]=1 for exactly this cycle; timer cleared to 0; go to WAIT.
- WAIT: only bit cur_stage of stage_done/stage_error is observed; other bits are ignored. The timer increments each cycle.
- Priority in WAIT, evaluated the same cycle:
  - Error: stage_error beats stage_done when both are high in the same cycle.
  - Timeout: timer == TIMEOUT-1 with neither done nor error is a timeout (TIMEOUT != 0 only).
  - Done: if the last stage, go to OK; else cur_stage+1, retry_cnt=0, go to LAUNCH.
  - Error/timeout: if retry_cnt < MAX_RETRY, retry_cnt+1 and go to LAUNCH (same stage re-pulsed next cycle). Otherwise latch fail_stage=cur_stage and fail_to, then go to FAIL.
- OK: init_ok=1 for one cycle, then IDLE. FAIL: init_fail=1 for one cycle, then IDLE.
- Latency: stage done in cycle D gives stage_en[k+1] at D+1; last-stage done at D gives init_ok at D+1. Minimum total latency for N stages each answering in the cycle after their stage_en is 2*N+1 cycles from init_start to init_ok.
- init_start while not IDLE is ignored (no queuing). In the OK/FAIL cycle the block is not IDLE, so init_start there is also ignored.
- init_ok and init_fail are never high together. At most one stage_en bit is high in any cycle.
- Timer saturates logic-wise: it is never compared beyond TIMEOUT-1, and wrap-around is impossible.

Optional Feature:
- Macro: AIO_INIT_SKIP_EN.
- When defined:
  - Adds input stage_skip [N_STAGE-1:0], latched on the accepted init_start.
  - In LAUNCH, a skipped stage gets no stage_en pulse and advances immediately: next stage LAUNCH the following cycle, or OK if last.
  - An all-ones mask gives init_ok N_STAGE+1 cycles after init_start.
- When undefined: no port; every stage is always executed.

Test Plan:
- N_STAGE=4, TIMEOUT=16, MAX_RETRY=1, each stage answers stage_done one cycle after its stage_en -> stage_en 0001,0010,0100,1000 at T+1,T+3,T+5,T+7; init_ok at T+9; init_fail never set.
- Stage 2 asserts stage_error once, then done on the retry -> stage_en[2] pulsed twice, retry_cnt=1 then 0 at stage 3; init_ok pulse; fail_stage stays 0.
- Stage 1 never responds -> stage_en[1] re-pulsed after 16 WAIT cycles; after the second timeout init_fail pulses with fail_stage=1, fail_to=1, init_busy drops the cycle after.
- Stage 0 asserts done and error in the same cycle, twice -> error wins; init_fail with fail_stage=0, fail_to=0; no stage_en[1] ever.
- glbl_rst asserted while in WAIT on stage 3, plus init_start pulses while busy and wrong-stage done bits -> all outputs 0 the cycle after reset; busy-time starts and foreign bits cause no effect.
- With AIO_INIT_SKIP_EN, stage_skip=4'b0101 -> only stage_en[1] and stage_en[3] pulse; init_ok follows stage 3 done by one cycle.

Source files
------------

// File: rtl/aio_init_seq.sv
// aio_init_seq: parametrised board-initialisation sequencer.
// Runs N_STAGE init engines strictly in order. Each stage receives a one-cycle
// stage_en pulse, then the sequencer waits for that stage's done/error with a
// per-attempt timeout watchdog and bounded retries. The first failing stage and
// its cause are latched for diagnostics.
//
// Optional feature (macro AIO_INIT_SKIP_EN): adds input stage_skip, a per-stage
// bypass mask latched on the accepted init_start.
//
// Ports:
//   sys_clk      - system clock, rising edge
//   glbl_rst     - synchronous active-high reset
//   init_start   - start request, only honoured in IDLE
//   init_busy    - high from first stage_en through the init_ok/init_fail pulse
//   init_ok      - one-cycle pulse, every stage completed
//   init_fail    - one-cycle pulse, a stage failed after all retries
//   fail_stage   - latched index of the failing stage
//   fail_to      - latched cause: 1 = timeout, 0 = stage_error
//   cur_stage    - index of the stage currently running
//   retry_cnt    - retries used on the current stage
//   stage_en     - one-hot one-cycle start pulse per stage
//   stage_done   - per-stage completion
//   stage_error  - per-stage error
//   stage_skip   - per-stage bypass mask (AIO_INIT_SKIP_EN only)
module aio_init_seq #(
  parameter int N_STAGE   = 4,
  parameter int STG_W     = 4,
  parameter int TO_W      = 20,
  parameter int TIMEOUT   = 500000,
  parameter int MAX_RETRY = 2,
  parameter int RTY_W     = 2
) (
  input  logic               sys_clk,
  input  logic               glbl_rst,
  input  logic               init_start,
  output logic               init_busy,
  output logic               init_ok,
  output logic               init_fail,
  output logic [STG_W-1:0]   fail_stage,
  output logic               fail_to,
  output logic [STG_W-1:0]   cur_stage,
  output logic [RTY_W-1:0]   retry_cnt,
  output logic [N_STAGE-1:0] stage_en,
`ifdef AIO_INIT_SKIP_EN
  input  logic [N_STAGE-1:0] stage_skip,
`endif
  input  logic [N_STAGE-1:0] stage_done,
  input  logic [N_STAGE-1:0] stage_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_OK,
    S_FAIL
  } state_e;

  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  localparam logic [STG_W-1:0] LAST_STG  = STG_W'(N_STAGE - 1);
  localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRY);

  state_e             state_q, state_d;
  logic [STG_W-1:0]   cur_q, cur_d;
  logic [RTY_W-1:0]   rty_q, rty_d;
  logic [TO_W-1:0]    tmr_q, tmr_d;
  logic [STG_W-1:0]   fstg_q, fstg_d;
  logic               fto_q, fto_d;
`ifdef AIO_INIT_SKIP_EN
  logic [N_STAGE-1:0] skip_q, skip_d;
`endif

  logic cur_done, cur_err, cur_skip, to_hit, fault;

  always_ff @(posedge sys_clk) begin
    if (glbl_rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      rty_q   <= '0;
      tmr_q   <= '0;
      fstg_q  <= '0;
      fto_q   <= 1'b0;
`ifdef AIO_INIT_SKIP_EN
      skip_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rty_q   <= rty_d;
      tmr_q   <= tmr_d;
      fstg_q  <= fstg_d;
      fto_q   <= fto_d;
`ifdef AIO_INIT_SKIP_EN
      skip_q  <= skip_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    rty_d    = rty_q;
    tmr_d    = tmr_q;
    fstg_d   = fstg_q;
    fto_d    = fto_q;
`ifdef AIO_INIT_SKIP_EN
    skip_d   = skip_q;
`endif
    stage_en = '0;
    cur_done = 1'b0;
    cur_err  = 1'b0;
    cur_skip = 1'b0;

    // Select only the current stage's response bits; a decode loop keeps the
    // index width independent of N_STAGE.
    for (int unsigned k = 0; k < N_STAGE; k++) begin
      if (cur_q == STG_W'(k)) begin
        cur_done = stage_done[k];
        cur_err  = stage_error[k];
`ifdef AIO_INIT_SKIP_EN
        cur_skip = skip_q[k];
`endif
      end
    end

    // Timeout only when neither done nor error arrived in the final cycle.
    to_hit = (TIMEOUT != 0) && (tmr_q == TO_LAST);
    fault  = cur_err || (!cur_done && to_hit);

    case (state_q)
      S_IDLE: begin
        if (init_start) begin
          state_d = S_LAUNCH;
          cur_d   = '0;
          rty_d   = '0;
          fstg_d  = '0;
          fto_d   = 1'b0;
`ifdef AIO_INIT_SKIP_EN
          skip_d  = stage_skip;
`endif
        end
      end
      S_LAUNCH: begin
        tmr_d = '0;
        if (cur_skip) begin
          rty_d = '0;
          if (cur_q == LAST_STG) begin
            state_d = S_OK;
          end else begin
            cur_d = cur_q + 1'b1;
          end
        end else begin
          for (int unsigned k = 0; k < N_STAGE; k++) begin
            if (cur_q == STG_W'(k)) begin
              stage_en[k] = 1'b1;
            end
          end
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Saturate so the counter can never wrap back onto TO_LAST.
        if (tmr_q != '1) begin
          tmr_d = tmr_q + 1'b1;
        end
        if (fault) begin
          if (rty_q < RTY_LIMIT) begin
            rty_d   = rty_q + 1'b1;
            state_d = S_LAUNCH;
          end else begin
            fstg_d  = cur_q;
            fto_d   = !cur_err;
            state_d = S_FAIL;
          end
        end else if (cur_done) begin
          rty_d = '0;
          if (cur_q == LAST_STG) begin
            state_d = S_OK;
          end else begin
            cur_d   = cur_q + 1'b1;
            state_d = S_LAUNCH;
          end
        end
      end
      S_OK:    state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign init_busy  = (state_q != S_IDLE);
  assign init_ok    = (state_q == S_OK);
  assign init_fail  = (state_q == S_FAIL);
  assign fail_stage = fstg_q;
  assign fail_to    = fto_q;
  assign cur_stage  = cur_q;
  assign retry_cnt  = rty_q;

endmodule

// File: tb/tb_aio_init_seq.sv
// Scoreboard bench for aio_init_seq (N_STAGE=4, TIMEOUT=16, MAX_RETRY=1).
// Directed scenarios push hand-computed expected events (stage_en pulses and
// init_ok/init_fail pulses with their cycle numbers); a monitor pops and
// compares whenever the DUT presents one. A responder process answers each
// stage_en one cycle later from a scripted response queue.
module tb_aio_init_seq;

  localparam int R_DONE = 0;
  localparam int R_ERR  = 1;
  localparam int R_NONE = 2;
  localparam int R_BOTH = 3;

  logic       clk = 1'b0;
  logic       glbl_rst = 1'b1;
  logic       init_start = 1'b0;
  logic       init_busy, init_ok, init_fail, fail_to;
  logic [3:0] fail_stage, cur_stage, stage_en;
  logic [1:0] retry_cnt;
  logic [3:0] stage_done, stage_error;
  logic [3:0] resp_done = '0, resp_err = '0, fgn_done = '0, fgn_err = '0;
`ifdef AIO_INIT_SKIP_EN
  logic [3:0] stage_skip = '0;
`endif

  assign stage_done  = resp_done | fgn_done;
  assign stage_error = resp_err  | fgn_err;

  aio_init_seq #(
    .N_STAGE  (4),
    .STG_W    (4),
    .TO_W     (20),
    .TIMEOUT  (16),
    .MAX_RETRY(1),
    .RTY_W    (2)
  ) dut (
    .sys_clk    (clk),
    .glbl_rst   (glbl_rst),
    .init_start (init_start),
    .init_busy  (init_busy),
    .init_ok    (init_ok),
    .init_fail  (init_fail),
    .fail_stage (fail_stage),
    .fail_to    (fail_to),
    .cur_stage  (cur_stage),
    .retry_cnt  (retry_cnt),
    .stage_en   (stage_en),
`ifdef AIO_INIT_SKIP_EN
    .stage_skip (stage_skip),
`endif
    .stage_done (stage_done),
    .stage_error(stage_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         cyc;
    logic [3:0] en;
    logic       ok;
    logic       fl;
    logic [3:0] fs;
    logic       fto;
    logic [1:0] rty;
  } exp_t;

  exp_t exp_q[$];
  int   resp_q[$];

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic void exp_en(input int c, input logic [3:0] en, input logic [1:0] rty);
    exp_t e;
    e.cyc = c; e.en = en; e.ok = 1'b0; e.fl = 1'b0; e.fs = '0; e.fto = 1'b0; e.rty = rty;
    exp_q.push_back(e);
  endfunction

  function automatic void exp_end(input int c, input logic ok, input logic fl,
                                  input logic [3:0] fs, input logic fto);
    exp_t e;
    e.cyc = c; e.en = '0; e.ok = ok; e.fl = fl; e.fs = fs; e.fto = fto; e.rty = '0;
    exp_q.push_back(e);
  endfunction

  // Monitor: compare each presented event against the scoreboard head.
  always @(negedge clk) begin
    if (!glbl_rst && (stage_en != 0 || init_ok || init_fail)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: cyc=%0d en=%b ok=%b fail=%b, expected no event",
                 cyc, stage_en, init_ok, init_fail);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("stage_en", stage_en, e.en);
        chk("init_ok", init_ok, e.ok);
        chk("init_fail", init_fail, e.fl);
        chk("busy_at_event", init_busy, 1);
        if (e.en != 0) begin
          chk("retry_cnt", retry_cnt, e.rty);
        end else begin
          chk("fail_stage", fail_stage, e.fs);
          chk("fail_to", fail_to, e.fto);
        end
      end
    end
  end

  // Responder: answer each stage_en during the following (WAIT) cycle.
  initial begin
    logic [3:0] en_s;
    int r;
    forever begin
      @(negedge clk);
      if (!glbl_rst && stage_en != 0) begin
        en_s = stage_en;
        r = (resp_q.size() != 0) ? resp_q.pop_front() : R_NONE;
        @(posedge clk); #1;
        if (r == R_DONE || r == R_BOTH) resp_done = en_s;
        if (r == R_ERR  || r == R_BOTH) resp_err  = en_s;
        @(posedge clk); #1;
        resp_done = '0;
        resp_err  = '0;
      end
    end
  end

  task automatic goto(input int c);
    if (c < cyc) begin
      $display("FAIL goto: cycle %0d already passed, now %0d", c, cyc);
      bad++;
    end
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic start_seq(output int t);
    init_start = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    init_start = 1'b0;
  endtask

  task automatic drain(input string nm, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
    resp_q.delete();
    repeat (4) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_busy"}, init_busy, 0);
    chk({nm, "_ok"}, init_ok, 0);
    chk({nm, "_fail"}, init_fail, 0);
    chk({nm, "_fail_stage"}, fail_stage, 0);
    chk({nm, "_fail_to"}, fail_to, 0);
    chk({nm, "_cur_stage"}, cur_stage, 0);
    chk({nm, "_retry_cnt"}, retry_cnt, 0);
    chk({nm, "_stage_en"}, stage_en, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int t;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_zero("reset");
    glbl_rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end

    // All stages answer done immediately; a start during OK is ignored.
    resp_q = '{R_DONE, R_DONE, R_DONE, R_DONE};
    t = cyc;
    exp_en(t + 1, 4'b0001, 2'd0);
    exp_en(t + 3, 4'b0010, 2'd0);
    exp_en(t + 5, 4'b0100, 2'd0);
    exp_en(t + 7, 4'b1000, 2'd0);
    exp_end(t + 9, 1'b1, 1'b0, 4'd0, 1'b0);
    start_seq(t);
    goto(t + 9);
    init_start = 1'b1;
    goto(t + 10);
    init_start = 1'b0;
    chk("pass_busy_after_ok", init_busy, 0);
    drain("pass", 20);

    // Stage 2 errors once, then succeeds on retry.
    resp_q = '{R_DONE, R_DONE, R_ERR, R_DONE, R_DONE};
    t = cyc;
    exp_en(t + 1, 4'b0001, 2'd0);
    exp_en(t + 3, 4'b0010, 2'd0);
    exp_en(t + 5, 4'b0100, 2'd0);
    exp_en(t + 7, 4'b0100, 2'd1);
    exp_en(t + 9, 4'b1000, 2'd0);
    exp_end(t + 11, 1'b1, 1'b0, 4'd0, 1'b0);
    start_seq(t);
    drain("retry", 30);

    // Stage 1 never answers: two timeouts then failure.
    resp_q = '{R_DONE, R_NONE, R_NONE};
    t = cyc;
    exp_en(t + 1, 4'b0001, 2'd0);
    exp_en(t + 3, 4'b0010, 2'd0);
    exp_en(t + 20, 4'b0010, 2'd1);
    exp_end(t + 37, 1'b0, 1'b1, 4'd1, 1'b1);
    start_seq(t);
    goto(t + 38);
    chk("timeout_busy_after_fail", init_busy, 0);
    chk("timeout_latched_stage", fail_stage, 1);
    chk("timeout_latched_to", fail_to, 1);
    drain("timeout", 10);

    // Stage 0 reports done and error together twice: error wins.
    resp_q = '{R_BOTH, R_BOTH};
    t = cyc;
    exp_en(t + 1, 4'b0001, 2'd0);
    exp_en(t + 3, 4'b0001, 2'd1);
    exp_end(t + 5, 1'b0, 1'b1, 4'd0, 1'b0);
    start_seq(t);
    goto(t + 2);
    chk("both_cleared_stage", fail_stage, 0);
    chk("both_cleared_to", fail_to, 0);
    drain("both", 20);

    // Foreign bits and a busy-time start, then reset while waiting on stage 3.
    resp_q = '{R_DONE, R_DONE, R_DONE, R_NONE};
    t = cyc;
    exp_en(t + 1, 4'b0001, 2'd0);
    exp_en(t + 3, 4'b0010, 2'd0);
    exp_en(t + 5, 4'b0100, 2'd0);
    exp_en(t + 7, 4'b1000, 2'd0);
    start_seq(t);
    goto(t + 4);
    fgn_done   = 4'b1101;
    fgn_err    = 4'b1101;
    init_start = 1'b1;
    goto(t + 5);
    fgn_done   = '0;
    fgn_err    = '0;
    init_start = 1'b0;
    goto(t + 10);
    chk("midrst_cur_stage", cur_stage, 3);
    glbl_rst = 1'b1;
    goto(t + 11);
    check_zero("midrst");
    glbl_rst = 1'b0;
    drain("midrst", 5);

`ifdef AIO_INIT_SKIP_EN
    // Stages 0 and 2 bypassed.
    stage_skip = 4'b0101;
    resp_q = '{R_DONE, R_DONE};
    t = cyc;
    exp_en(t + 2, 4'b0010, 2'd0);
    exp_en(t + 5, 4'b1000, 2'd0);
    exp_end(t + 7, 1'b1, 1'b0, 4'd0, 1'b0);
    start_seq(t);
    stage_skip = '0;
    drain("skip", 20);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
